// File: rtl/riscv_core_dcache_controller.sv
// Control FSM of the direct-mapped, write-back, write-allocate L1 data cache.
// It holds the tag, valid and dirty state and sequences victim writeback and line refill over AXI.
module riscv_core_dcache_controller #(
    parameter int INDEX_WIDTH = 7,
    parameter int TAG_WIDTH   = 52,
    parameter int ADDR_WIDTH  = 64,
    parameter int LINE_OFFSET = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    input  logic                   i_req_we,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic                   o_stall,
    output logic                   o_mem_rd_en,
    output logic                   o_mem_wr_en,
    output logic                   o_block_replace,
    output logic [INDEX_WIDTH-1:0] o_mem_index,
    output logic                   o_axi_rd_req,
    output logic [ADDR_WIDTH-1:0]  o_axi_rd_addr,
    input  logic                   i_axi_rd_done,
    output logic                   o_axi_wr_req,
    output logic [ADDR_WIDTH-1:0]  o_axi_wr_addr,
    input  logic                   i_axi_wr_done,
    output logic                   o_busy
);

    localparam int CACHE_DEPTH = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        RETRY     = 2'd3
    } state_t;

    state_t                 state_q;
    logic [TAG_WIDTH-1:0]   tag_q [CACHE_DEPTH];
    logic [CACHE_DEPTH-1:0] valid_q;
    logic [CACHE_DEPTH-1:0] dirty_q;

    logic [TAG_WIDTH-1:0]   addr_tag;
    logic [INDEX_WIDTH-1:0] index;
    logic                   hit;
    logic                   access_state;
    logic                   store_hit;
    logic                   refill_done;
    logic                   unused_offset;

    assign addr_tag      = i_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign index         = i_addr[LINE_OFFSET +: INDEX_WIDTH];
    assign hit           = i_req_valid & valid_q[index] & (tag_q[index] == addr_tag);
    assign access_state  = (state_q == IDLE) || (state_q == RETRY);
    assign store_hit     = access_state & hit & i_req_we;
    assign refill_done   = (state_q == REFILL) & i_axi_rd_done;
    assign o_mem_index   = index;
    assign unused_offset = ^i_addr[LINE_OFFSET-1:0];

    // Outputs decode from the registered state so an asynchronous reset drops the AXI requests at once.
    always_comb begin
        o_stall         = 1'b0;
        o_mem_rd_en     = 1'b0;
        o_mem_wr_en     = 1'b0;
        o_block_replace = 1'b0;
        o_axi_rd_req    = 1'b0;
        o_axi_rd_addr   = '0;
        o_axi_wr_req    = 1'b0;
        o_axi_wr_addr   = '0;
        o_busy          = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    o_stall     = ~hit;
                    o_mem_rd_en = hit & ~i_req_we;
                    o_mem_wr_en = hit & i_req_we;
                end
            end
            WRITEBACK: begin
                o_stall       = 1'b1;
                o_mem_rd_en   = 1'b1;
                o_axi_wr_req  = 1'b1;
                o_axi_wr_addr = {tag_q[index], index, {LINE_OFFSET{1'b0}}};
            end
            REFILL: begin
                o_stall         = 1'b1;
                o_axi_rd_req    = 1'b1;
                o_axi_rd_addr   = {i_addr[ADDR_WIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
                o_mem_wr_en     = i_axi_rd_done;
                o_block_replace = i_axi_rd_done;
            end
            RETRY: begin
                o_mem_rd_en = hit & ~i_req_we;
                o_mem_wr_en = hit & i_req_we;
            end
            default: ;
        endcase
    end

    // NOTE: the tag array is storage, not control state; valid bits qualify it, so it takes no reset.
    always_ff @(posedge i_clk) begin
        if (refill_done) begin
            tag_q[index] <= addr_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every update lands together at the edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (store_hit) begin
                dirty_q[index] <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (i_req_valid && !hit) begin
                        state_q <= (valid_q[index] && dirty_q[index]) ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (i_axi_wr_done) begin
                        dirty_q[index] <= 1'b0;
                        state_q        <= REFILL;
                    end
                end
                REFILL: begin
                    if (i_axi_rd_done) begin
                        valid_q[index] <= 1'b1;
                        dirty_q[index] <= 1'b0;
                        state_q        <= RETRY;
                    end
                end
                RETRY:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core_dcache_controller.sv
// Directed bench for the L1 data-cache controller: refill, store hit, dirty eviction,
// stray done pulses, reset abort and back-to-back hits.
module tb_riscv_core_dcache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [63:0] addr;
    logic        o_stall;
    logic        o_mem_rd_en;
    logic        o_mem_wr_en;
    logic        o_block_replace;
    logic [6:0]  o_mem_index;
    logic        o_axi_rd_req;
    logic [63:0] o_axi_rd_addr;
    logic        rd_done;
    logic        o_axi_wr_req;
    logic [63:0] o_axi_wr_addr;
    logic        wr_done;
    logic        o_busy;

    int checks = 0;
    int errors = 0;
    logic overlap_seen = 1'b0;

    // {stall, rd_en, wr_en, block_replace, axi_rd_req, axi_wr_req, busy}
    logic [6:0] ctl;
    assign ctl = {o_stall, o_mem_rd_en, o_mem_wr_en, o_block_replace,
                  o_axi_rd_req, o_axi_wr_req, o_busy};

    localparam logic [6:0] C_IDLE      = 7'b0000000;
    localparam logic [6:0] C_MISS      = 7'b1000000;
    localparam logic [6:0] C_LOAD_HIT  = 7'b0100000;
    localparam logic [6:0] C_STORE_HIT = 7'b0010000;
    localparam logic [6:0] C_WB        = 7'b1100011;
    localparam logic [6:0] C_REFILL    = 7'b1000101;
    localparam logic [6:0] C_REF_DONE  = 7'b1011101;
    localparam logic [6:0] C_RETRY_LD  = 7'b0100001;

    riscv_core_dcache_controller dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req_valid     (req_valid),
        .i_req_we        (req_we),
        .i_addr          (addr),
        .o_stall         (o_stall),
        .o_mem_rd_en     (o_mem_rd_en),
        .o_mem_wr_en     (o_mem_wr_en),
        .o_block_replace (o_block_replace),
        .o_mem_index     (o_mem_index),
        .o_axi_rd_req    (o_axi_rd_req),
        .o_axi_rd_addr   (o_axi_rd_addr),
        .i_axi_rd_done   (rd_done),
        .o_axi_wr_req    (o_axi_wr_req),
        .o_axi_wr_addr   (o_axi_wr_addr),
        .i_axi_wr_done   (wr_done),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    always @(o_axi_rd_req or o_axi_wr_req) begin
        if (o_axi_rd_req && o_axi_wr_req) overlap_seen = 1'b1;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(o_stall && !req_valid))
            else $error("protocol violation: request dropped while stalled");
        end
    end

    // Drives one access to completion, answering whichever AXI request is raised.
    task automatic fill_line(input logic [63:0] a, input logic we);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; addr = a;
        #2;
        for (int k = 0; k < 40 && o_stall; k++) begin
            if (o_axi_rd_req) rd_done = 1'b1;
            else if (o_axi_wr_req) wr_done = 1'b1;
            @(negedge clk);
            rd_done = 1'b0; wr_done = 1'b0;
            #2;
        end
        checks++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL fill_timeout addr=%h: stall still %b, required 0", a, o_stall);
        end
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; addr = '0;
        rd_done = 1'b0; wr_done = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({ctl, o_axi_rd_addr, o_axi_wr_addr} !== {C_IDLE, 64'h0, 64'h0}) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b rd_addr=%h wr_addr=%h, required all zero",
                     ctl, o_axi_rd_addr, o_axi_wr_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL idle_after_reset: ctl=%b, required %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_load_miss_refill();
        int stalled = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; addr = 64'h1040;
        #2;
        stalled += int'(o_stall);
        checks++;
        if (ctl !== C_MISS) begin
            errors++;
            $display("FAIL miss_detect: ctl=%b, required %b", ctl, C_MISS);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #2;
            stalled += int'(o_stall);
            checks++;
            if ({ctl, o_axi_rd_addr} !== {C_REFILL, 64'h1040}) begin
                errors++;
                $display("FAIL refill_wait%0d: ctl=%b rd_addr=%h, required %b 1040", k, ctl, o_axi_rd_addr, C_REFILL);
            end
        end
        @(negedge clk);
        rd_done = 1'b1;
        #2;
        stalled += int'(o_stall);
        checks++;
        if (ctl !== C_REF_DONE) begin
            errors++;
            $display("FAIL refill_done: ctl=%b, required %b", ctl, C_REF_DONE);
        end
        @(negedge clk);
        rd_done = 1'b0;
        #2;
        stalled += int'(o_stall);
        checks++;
        if (ctl !== C_RETRY_LD) begin
            errors++;
            $display("FAIL retry_load: ctl=%b, required %b", ctl, C_RETRY_LD);
        end
        checks++;
        if (stalled !== 7) begin
            errors++;
            $display("FAIL stall_cycles: got %0d, required 7", stalled);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL back_to_idle: ctl=%b, required %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_store_hit();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; addr = 64'h1048;
        #2;
        checks++;
        if (ctl !== C_STORE_HIT) begin
            errors++;
            $display("FAIL store_hit: ctl=%b, required %b", ctl, C_STORE_HIT);
        end
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        #2;
        checks++;
        if (dut.dirty_q[2] !== 1'b1) begin
            errors++;
            $display("FAIL store_sets_dirty: dirty[2]=%b, required 1", dut.dirty_q[2]);
        end
    endtask

    task automatic test_dirty_evict();
        overlap_seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; addr = 64'h2040;
        #2;
        checks++;
        if (ctl !== C_MISS) begin
            errors++;
            $display("FAIL evict_miss_detect: ctl=%b, required %b", ctl, C_MISS);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wr_done = (k == 3);
            #2;
            checks++;
            if ({ctl, o_axi_wr_addr} !== {C_WB, 64'h1040}) begin
                errors++;
                $display("FAIL writeback%0d: ctl=%b wr_addr=%h, required %b 1040", k, ctl, o_axi_wr_addr, C_WB);
            end
        end
        @(negedge clk);
        wr_done = 1'b0;
        #2;
        checks++;
        if ({ctl, o_axi_rd_addr, dut.dirty_q[2]} !== {C_REFILL, 64'h2040, 1'b0}) begin
            errors++;
            $display("FAIL evict_refill: ctl=%b rd_addr=%h dirty=%b, required %b 2040 0",
                     ctl, o_axi_rd_addr, dut.dirty_q[2], C_REFILL);
        end
        @(negedge clk);
        rd_done = 1'b1;
        #2;
        checks++;
        if (ctl !== C_REF_DONE) begin
            errors++;
            $display("FAIL evict_refill_done: ctl=%b, required %b", ctl, C_REF_DONE);
        end
        @(negedge clk);
        rd_done = 1'b0;
        #2;
        checks++;
        if (ctl !== C_RETRY_LD) begin
            errors++;
            $display("FAIL evict_retry: ctl=%b, required %b", ctl, C_RETRY_LD);
        end
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        checks++;
        if ({overlap_seen, dut.dirty_q[2]} !== 2'b00) begin
            errors++;
            $display("FAIL evict_end: overlap=%b dirty=%b, required 0 0", overlap_seen, dut.dirty_q[2]);
        end
    endtask

    task automatic test_stray_done();
        @(negedge clk);
        rd_done = 1'b1;
        #2;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL stray_rd_idle: ctl=%b, required %b", ctl, C_IDLE);
        end
        @(negedge clk);
        rd_done = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; addr = 64'h2040;
        #2;
        checks++;
        if (ctl !== C_LOAD_HIT) begin
            errors++;
            $display("FAIL stray_no_update: ctl=%b, required %b", ctl, C_LOAD_HIT);
        end
        // Done arriving together with the miss must not complete it.
        @(negedge clk);
        addr = 64'h3040; rd_done = 1'b1;
        #2;
        checks++;
        if (ctl !== C_MISS) begin
            errors++;
            $display("FAIL done_with_miss: ctl=%b, required %b", ctl, C_MISS);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rd_done = 1'b0;
            wr_done = (k == 1);
            #2;
            checks++;
            if ({ctl, dut.valid_q[2], dut.dirty_q[2]} !== {C_REFILL, 2'b10}) begin
                errors++;
                $display("FAIL stray_wr_refill%0d: ctl=%b valid=%b dirty=%b, required %b 1 0",
                         k, ctl, dut.valid_q[2], dut.dirty_q[2], C_REFILL);
            end
        end
        @(negedge clk);
        wr_done = 1'b0; rd_done = 1'b1;
        #2;
        checks++;
        if (ctl !== C_REF_DONE) begin
            errors++;
            $display("FAIL stray_refill_done: ctl=%b, required %b", ctl, C_REF_DONE);
        end
        @(negedge clk);
        rd_done = 1'b0;
        #2;
        checks++;
        if (ctl !== C_RETRY_LD) begin
            errors++;
            $display("FAIL stray_retry: ctl=%b, required %b", ctl, C_RETRY_LD);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; addr = 64'h2040;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (ctl !== C_REFILL) begin
            errors++;
            $display("FAIL abort_setup: ctl=%b, required %b", ctl, C_REFILL);
        end
        rst = 1'b1; req_valid = 1'b0;
        #1;
        checks++;
        if ({ctl, o_axi_rd_addr} !== {C_IDLE, 64'h0}) begin
            errors++;
            $display("FAIL abort_async: ctl=%b rd_addr=%h, required all zero", ctl, o_axi_rd_addr);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; addr = 64'h2040;
        #2;
        checks++;
        if ({ctl, dut.valid_q[2]} !== {C_MISS, 1'b0}) begin
            errors++;
            $display("FAIL abort_remiss: ctl=%b valid=%b, required %b 0", ctl, dut.valid_q[2], C_MISS);
        end
        fill_line(64'h2040, 1'b0);
    endtask

    task automatic test_back_to_back();
        fill_line(64'h1000, 1'b0);
        fill_line(64'h1020, 1'b0);
        fill_line(64'h1040, 1'b0);
        fill_line(64'h1060, 1'b0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = (i % 2 == 1); addr = 64'h1000 + 64'(8 * i);
            #2;
            checks++;
            if ({ctl, o_mem_index} !== {(req_we ? C_STORE_HIT : C_LOAD_HIT), 7'(i / 4)}) begin
                errors++;
                $display("FAIL b2b_%0d: ctl=%b index=%0d, required %b %0d",
                         i, ctl, o_mem_index, (req_we ? C_STORE_HIT : C_LOAD_HIT), i / 4);
            end
        end
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        #2;
        checks++;
        if (dut.dirty_q[3:0] !== 4'b1111) begin
            errors++;
            $display("FAIL b2b_dirty: dirty[3:0]=%b, required 1111", dut.dirty_q[3:0]);
        end
    endtask

    initial begin
        test_reset();
        test_load_miss_refill();
        test_store_hit();
        test_dirty_evict();
        test_stray_done();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
